// File: rtl/cycle_cooling_pkg.sv
// Shared types for the cycle cooling fan controller:
// FSM state encoding and fan level type.
package cycle_cooling_pkg;

    localparam int LEVELS = 4;

    typedef logic [1:0] level_t;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        SPINUP   = 3'd1,
        RUN      = 3'd2,
        COOLDOWN = 3'd3,
        FAULT    = 3'd4
    } state_e;

endpackage

// File: rtl/cycle_cooling_controller_pwm.sv
// Free-running PWM counter and comparator for the fan drive.
// Output is registered against the counter value it is shown with.
module cooling_pwm
    import cycle_cooling_pkg::*;
#(
    parameter int PWM_W = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  level_t level,
    input  logic   force_on,
    input  logic   force_off,
    output logic   fan
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] cnt_n;
    logic [PWM_W-1:0] duty;

    assign cnt_n = cnt + PWM_W'(1);
    assign duty  = PWM_W'(level) << (PWM_W - 2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            fan <= 1'b0;
        end else begin
            cnt <= cnt_n;
            fan <= !force_off && (force_on || (cnt_n < duty));
        end
    end

endmodule

// File: rtl/cycle_cooling_controller.sv
// Cycle cooling fan controller: sensor fusion with hysteresis,
// spin-up / cool-down timing and blocked-duct fault detection.
module cycle_cooling_controller
    import cycle_cooling_pkg::*;
#(
    parameter int SENSOR_W        = 3,
    parameter int PWM_W           = 4,
    parameter int TH1             = 4,
    parameter int TH2             = 8,
    parameter int TH3             = 11,
    parameter int HYST            = 1,
    parameter int SPINUP_CYCLES   = 16,
    parameter int COOLDOWN_CYCLES = 64,
    parameter int FAULT_SAMPLES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SENSOR_W-1:0] calorie,
    input  logic [SENSOR_W-1:0] temperature,
    input  logic                pressure,
    input  logic                air_pressure,
    input  logic                fault_clr,
    output logic                fan,
    output logic [1:0]          fan_level,
    output logic                alarm,
    output logic [2:0]          state
);

    localparam int TMAX = (SPINUP_CYCLES > COOLDOWN_CYCLES) ?
                          SPINUP_CYCLES : COOLDOWN_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int FW = $clog2(FAULT_SAMPLES + 1);
    localparam logic [TW-1:0] SPIN_LD = TW'(SPINUP_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LD = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [FW-1:0] FLIM    = FW'(FAULT_SAMPLES);
    localparam level_t        LTOP    = level_t'(LEVELS - 1);

    state_e        st, st_n;
    level_t        lvl, lvl_n, lvl_step;
    logic [TW-1:0] tmr, tmr_n;
    logic [FW-1:0] fcnt, fcnt_n, fcnt_inc;
    logic [SENSOR_W:0] score;
    int            score_i;
    logic          start;

    function automatic int th(input level_t l);
        case (l)
            2'd1:    th = TH1;
            2'd2:    th = TH2;
            2'd3:    th = TH3;
            default: th = 0;
        endcase
    endfunction

    assign score    = {1'b0, calorie} + {1'b0, temperature};
    assign score_i  = int'(score);
    assign start    = sample_valid && pressure && (score_i >= TH1);
    assign fcnt_inc = fcnt + FW'(1);

    // At most one level step per accepted sample
    always_comb begin
        lvl_step = lvl;
        if (lvl != LTOP && score_i >= th(lvl + level_t'(1)))
            lvl_step = lvl + level_t'(1);
        else if (lvl != '0 && score_i < th(lvl) - HYST)
            lvl_step = lvl - level_t'(1);
    end

    always_comb begin
        st_n   = st;
        lvl_n  = lvl;
        tmr_n  = tmr;
        fcnt_n = fcnt;
        unique case (st)
            OFF: begin
                lvl_n  = '0;
                fcnt_n = '0;
                if (start) begin
                    st_n  = SPINUP;
                    lvl_n = level_t'(1);
                    tmr_n = SPIN_LD;
                end
            end
            SPINUP, RUN: begin
                if (tmr != '0)
                    tmr_n = tmr - TW'(1);
                if (st == SPINUP && tmr == '0)
                    st_n = RUN;
                if (sample_valid) begin
                    fcnt_n = air_pressure ? '0 : fcnt_inc;
                    if (!air_pressure && fcnt_inc == FLIM) begin
                        st_n   = FAULT;
                        lvl_n  = '0;
                        fcnt_n = '0;
                    end else if (!pressure) begin
                        st_n   = COOLDOWN;
                        lvl_n  = level_t'(1);
                        tmr_n  = COOL_LD;
                        fcnt_n = '0;
                    end else begin
                        lvl_n = lvl_step;
                    end
                end
                if (st_n == RUN && lvl_n == '0) begin
                    st_n   = OFF;
                    fcnt_n = '0;
                end
            end
            COOLDOWN: begin
                lvl_n  = level_t'(1);
                fcnt_n = '0;
                if (start) begin
                    st_n  = RUN;
                    tmr_n = '0;
                end else if (tmr == '0) begin
                    st_n  = OFF;
                    lvl_n = '0;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            FAULT: begin
                lvl_n  = '0;
                fcnt_n = '0;
                if (fault_clr)
                    st_n = OFF;
            end
            default: begin
                st_n  = OFF;
                lvl_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= OFF;
            lvl   <= '0;
            tmr   <= '0;
            fcnt  <= '0;
            alarm <= 1'b0;
        end else begin
            st    <= st_n;
            lvl   <= lvl_n;
            tmr   <= tmr_n;
            fcnt  <= fcnt_n;
            alarm <= (st_n == FAULT);
        end
    end

    cooling_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .level     (lvl_n),
        .force_on  ((st_n == SPINUP) || (lvl_n == LTOP)),
        .force_off ((st_n == OFF) || (st_n == FAULT)),
        .fan       (fan)
    );

    assign fan_level = lvl;
    assign state     = st;

endmodule
